// File: rtl/reaction_round_ctrl_if.sv
// Signal bundle between the reaction round controller and the KEY/display logic.
// Latency: none, purely structural.
// Backpressure: none; start/btn are level inputs, results are held registers.
interface reaction_round_ctrl_if #(
  parameter int PLAYERS = 2,
  parameter int TIME_W  = 14
);
  logic                      start;
  logic [PLAYERS-1:0]        btn;
  logic                      light;
  logic                      busy;
  logic                      done;
  logic [1:0]                winner;
  logic                      winner_valid;
  logic [PLAYERS*TIME_W-1:0] react_ms;
  logic [PLAYERS-1:0]        false_start;
  logic [TIME_W-1:0]         best_ms;

  modport master (
    output start, btn,
    input  light, busy, done, winner, winner_valid, react_ms, false_start, best_ms
  );

  modport slave (
    input  start, btn,
    output light, busy, done, winner, winner_valid, react_ms, false_start, best_ms
  );
endinterface

// File: rtl/reaction_round_ctrl.sv
// Reaction-time round controller: LFSR pre-light delay, per-player ms timing, false starts, winner pick.
// Latency: busy 1 clk after start; light delay*TICK_DIV clk after ARM entry; press to react_ms 2 clk.
// Backpressure: none; start is ignored while busy, results hold until the next accepted start.
// Optional best-time tracker built only when REACTION_BEST_EN is defined.
module reaction_round_ctrl #(
  parameter int PLAYERS      = 2,
  parameter int LFSR_W       = 8,
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int DELAY_SHIFT  = 2,
  parameter int TIME_W       = 14,
  parameter int TIMEOUT_MS   = 9999
) (
  input logic                  clk,
  input logic                  rst_n,
  reaction_round_ctrl_if.slave io
);

  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DLY_MAX = MIN_DELAY_MS + (255 << DELAY_SHIFT);
  localparam int DLY_W   = $clog2(DLY_MAX + 1);

  // Right-shifting Galois masks, maximal length for each supported width.
  localparam logic [15:0] TAPS_ALL =
    (LFSR_W == 8)  ? 16'h00B8 :
    (LFSR_W == 9)  ? 16'h0110 :
    (LFSR_W == 10) ? 16'h0240 :
    (LFSR_W == 11) ? 16'h0500 :
    (LFSR_W == 12) ? 16'h0E08 :
    (LFSR_W == 13) ? 16'h1C80 :
    (LFSR_W == 14) ? 16'h3802 :
    (LFSR_W == 15) ? 16'h6000 : 16'hB400;
  localparam logic [LFSR_W-1:0] TAPS = TAPS_ALL[LFSR_W-1:0];
  localparam logic [TIME_W-1:0] TMO  = TIME_W'(TIMEOUT_MS);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_GO, S_RESULT} state_t;

  state_t                    state_q, state_nxt;
  logic [LFSR_W-1:0]         lfsr_q;
  logic [PLAYERS-1:0]        btn_q, press_q;
  logic [DIV_W-1:0]          div_q;
  logic                      div_clr;
  logic                      tick;
  logic [DLY_W-1:0]          dly_q, dly_nxt, delay_calc;
  logic [TIME_W-1:0]         ela_q, ela_nxt;
  logic [PLAYERS*TIME_W-1:0] react_q, react_nxt;
  logic [PLAYERS-1:0]        fs_q, fs_nxt;
  logic [PLAYERS-1:0]        fin_q, fin_nxt;
  logic                      start_acc;
  logic                      win_found;
  logic [1:0]                win_idx;
  logic [TIME_W-1:0]         win_time;
  logic                      light_q, busy_q, done_q, win_valid_q;
  logic [1:0]                winner_q;

  assign tick       = (div_q == DIV_W'(TICK_DIV - 1));
  assign start_acc  = (state_q == S_IDLE) && io.start;
  assign delay_calc = DLY_W'(MIN_DELAY_MS + (int'(lfsr_q[7:0]) << DELAY_SHIFT));

  // Free-running LFSR, press edge register and ms tick divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= LFSR_W'(1);
      btn_q   <= '0;
      press_q <= '0;
      div_q   <= '0;
    end else begin
      lfsr_q  <= {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
      btn_q   <= io.btn;
      press_q <= io.btn & ~btn_q;
      if (div_clr || tick) div_q <= '0;
      else                 div_q <= div_q + 1'b1;
    end
  end

  // Next-state and round datapath: delay countdown, false starts, time capture, timeout fill.
  always_comb begin
    state_nxt = state_q;
    dly_nxt   = dly_q;
    ela_nxt   = ela_q;
    react_nxt = react_q;
    fs_nxt    = fs_q;
    fin_nxt   = fin_q;
    div_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (io.start) begin
          state_nxt = S_ARM;
          dly_nxt   = delay_calc;
          react_nxt = '0;
          fs_nxt    = '0;
          fin_nxt   = '0;
          div_clr   = 1'b1;
        end
      end
      S_ARM: begin
        fs_nxt = fs_q | press_q;
        if (tick && (dly_q != '0)) dly_nxt = dly_q - 1'b1;
        if (&fs_nxt) begin
          state_nxt = S_RESULT;
        end else if ((dly_q == '0) || (tick && (dly_q == DLY_W'(1)))) begin
          state_nxt = S_GO;
          ela_nxt   = '0;
          div_clr   = 1'b1;
        end
      end
      S_GO: begin
        for (int i = 0; i < PLAYERS; i++) begin
          if (press_q[i] && !fs_q[i] && !fin_q[i]) begin
            react_nxt[i*TIME_W +: TIME_W] = ela_q;
            fin_nxt[i]                    = 1'b1;
          end
        end
        if (tick && (ela_q != TMO)) ela_nxt = ela_q + 1'b1;
        if (&(fin_nxt | fs_q)) begin
          state_nxt = S_RESULT;
        end else if (ela_q == TMO) begin
          state_nxt = S_RESULT;
          for (int i = 0; i < PLAYERS; i++) begin
            if (!fin_nxt[i] && !fs_q[i]) react_nxt[i*TIME_W +: TIME_W] = TMO;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Winner search on the values being committed, so results land together with done.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_time  = '1;
    for (int i = 0; i < PLAYERS; i++) begin
      if (fin_nxt[i] && !fs_nxt[i] &&
          (!win_found || (react_nxt[i*TIME_W +: TIME_W] < win_time))) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
        win_time  = react_nxt[i*TIME_W +: TIME_W];
      end
    end
  end

  // FSM state and round data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      ela_q   <= '0;
      react_q <= '0;
      fs_q    <= '0;
      fin_q   <= '0;
    end else begin
      state_q <= state_nxt;
      dly_q   <= dly_nxt;
      ela_q   <= ela_nxt;
      react_q <= react_nxt;
      fs_q    <= fs_nxt;
      fin_q   <= fin_nxt;
    end
  end

  // Registered status outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      light_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      winner_q    <= '0;
      win_valid_q <= 1'b0;
    end else begin
      light_q <= (state_nxt == S_GO);
      busy_q  <= (state_nxt == S_ARM) || (state_nxt == S_GO);
      done_q  <= (state_nxt == S_RESULT);
      if (state_nxt == S_RESULT) begin
        winner_q    <= win_idx;
        win_valid_q <= win_found;
      end else if (start_acc) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  assign io.light        = light_q;
  assign io.busy         = busy_q;
  assign io.done         = done_q;
  assign io.winner       = winner_q;
  assign io.winner_valid = win_valid_q;
  assign io.react_ms     = react_q;
  assign io.false_start  = fs_q;

`ifdef REACTION_BEST_EN
  logic [TIME_W-1:0] best_q, win_time_q;

  // Winning time captured as the round closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      win_time_q <= '1;
    else if (state_nxt == S_RESULT)  win_time_q <= win_time;
  end

  // Running best folds in the winner during the RESULT cycle; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      best_q <= '1;
    else if ((state_q == S_RESULT) && win_valid_q && (win_time_q < best_q))
      best_q <= win_time_q;
  end

  assign io.best_ms = best_q;
`else
  assign io.best_ms = '1;
`endif

endmodule

// File: doc/reaction_round_ctrl.md
# reaction_round_ctrl

Parametrised reaction-time round controller for the mini-games board. It runs complete multi-player rounds: an internal LFSR picks a random pre-light delay, then the block lights the start lamp and times each player's button press in millisecond ticks. It flags false starts and picks a winner. It sits between the debounced KEY inputs and the HEX/LEDR display logic, replacing the separate 1 Hz LFSR and start-timer pair with a single-clock, tick-enabled design.

## Interface
Parameters:
- PLAYERS, 2: number of player buttons, legal range 1..4.
- LFSR_W, 8: LFSR width, legal range 8..16. Fixed maximal-length taps per width.
- TICK_DIV, 50000: clk cycles per ms tick. 50000 gives 1 ms at 50 MHz.
- MIN_DELAY_MS, 1000: minimum pre-light delay in ms.
- DELAY_SHIFT, 2: left shift applied to the random delay component.
- TIME_W, 14: width of each reaction-time field.
- TIMEOUT_MS, 9999: ms after the light at which the round ends.

Ports:
- clk, in, 1: single system clock (CLOCK_50).
- rst_n, in, 1: reset, asynchronous and active-low.
- start, in, 1: request a new round. Sampled only in IDLE.
- btn, in, PLAYERS: player buttons, active-high, already debounced and synchronised.
- light, out, 1: start lamp, high only in GO.
- busy, out, 1: high in ARM and GO.
- done, out, 1: one-cycle pulse when a round completes.
- winner, out, 2: index of the winning player.
- winner_valid, out, 1: a winner exists for the last round.
- react_ms, out, PLAYERS*TIME_W: per-player reaction time; player i occupies bits [i*TIME_W +: TIME_W].
- false_start, out, PLAYERS: per-player false-start flags for the last round.
- best_ms, out, TIME_W: best time across rounds (see Configuration).

## Operation
- The LFSR is Galois, advances every clk cycle and is reset to seed 1. Its value never reaches zero.
- The ms tick is a one-cycle pulse every TICK_DIV cycles. The divider restarts at 0 on entry to ARM and on entry to GO.
- Press detection is rising-edge only: btn & ~btn_q. A held button never generates a second event.
- FSM states: IDLE, ARM, GO, RESULT.
- **IDLE**: on start, the block captures delay = MIN_DELAY_MS + (lfsr[7:0] << DELAY_SHIFT) and moves to ARM. In the same cycle it clears react_ms, false_start and winner_valid.
- **ARM**: the block decrements the delay counter on each tick.
  - A press in ARM sets false_start[i]. That player is excluded for the rest of the round.
  - When the counter reaches 0, the block moves to GO.
  - If every player has false-started, the block moves to RESULT immediately.
- **GO**: an elapsed-ms counter starts at 0 and increments per tick, saturating at TIMEOUT_MS.
  - A player's first press latches the current counter into react_ms[i] and marks that player finished.
  - The block moves to RESULT when every non-false-started player has finished, or when the counter equals TIMEOUT_MS.
  - A player who has not pressed at timeout gets react_ms[i] = TIMEOUT_MS and is not eligible to win.
- **RESULT**: lasts one cycle, during which done = 1, then the block returns to IDLE.
  - winner is the eligible player with the minimum react_ms. Ties go to the lowest index.
  - winner_valid = 0 if no player is eligible.
  - The results hold until the next accepted start.
- Simultaneous presses in the same cycle latch equal times, so the tie rule applies.
- start while busy is ignored.
- rst_n asserted mid-round aborts the round. Every output returns to its reset value.

## Timing
- Reset values: light 0, busy 0, done 0, winner 0, winner_valid 0, react_ms 0, false_start 0, best_ms all-ones. LFSR = 1, FSM = IDLE.
- busy rises the cycle after start is sampled.
- light rises on the first cycle of GO, exactly delay × TICK_DIV cycles after ARM entry (±1 cycle for the state register).
- Press-to-latch latency is 2 cycles: one for the edge register, one for the capture.
- A press in the last ARM cycle counts as a false start. A press in the first GO cycle latches 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: REACTION_BEST_EN.
- Defined: best_ms updates in the RESULT cycle to min(best_ms, react_ms[winner]) when winner_valid is 1. It is cleared to all-ones only by rst_n.
- Undefined: best_ms is constant all-ones and the comparator logic is not built.

## Test plan
- **Single-player round**: PLAYERS=2, TICK_DIV=4, MIN_DELAY_MS=10, reset seed. Press btn[1] 37 ticks after light, btn[0] at 52 ticks.
  - Expect react_ms = {37, 52}... per field, react_ms[1]=37 and react_ms[0]=52.
  - Expect winner=1, winner_valid=1, done for 1 cycle.
- **False start**: press btn[0] during ARM, press btn[1] 20 ticks after light.
  - Expect false_start=2'b01, winner=1, react_ms[1]=20.
- **All false start**: both buttons pressed in ARM.
  - Expect light never rising, RESULT immediately, winner_valid=0, false_start=2'b11.
- **Tie and timeout**: tie by pressing both in the same cycle at 15 ticks; expect winner=0. In a second round, press nothing with TIMEOUT_MS=50; expect done 50 ticks after light, both react_ms=50, winner_valid=0.
- **Reset mid-GO**: assert rst_n low during GO.
  - Expect light=0 and busy=0 asynchronously, all outputs at reset values.
  - A start after release must begin a fresh ARM.
- **REACTION_BEST_EN defined**: run rounds with winning times 40, 25, 30. Expect best_ms = 40, then 25, then 25. With the macro undefined, expect best_ms = 16383.
